// File: rtl/time_set_ctrl_pkg.sv
// Shared types and limits for the time-set controller.
// Holds the FSM state enum, field_sel encoding, field maxima and field priority.
package time_set_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EDIT = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FLD_MS  = 2'd0,
      FLD_SEC = 2'd1,
      FLD_MIN = 2'd2,
      FLD_HR  = 2'd3
   } field_t;

   localparam logic [9:0] MS_MAX  = 10'd999;
   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [4:0] HR_MAX  = 5'd23;

   // Fixed priority ms > s > min > hr; caller qualifies with "any switch".
   function automatic field_t pick_field(
      input logic i_ms,
      input logic i_s,
      input logic i_min
   );
      if (i_ms)  return FLD_MS;
      if (i_s)   return FLD_SEC;
      if (i_min) return FLD_MIN;
      return FLD_HR;
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button front end: 2-flop sync, debounce, rise detect, auto-repeat.
// Ports: clk, rst_n, i_btn (raw button), o_pulse (registered 1-cycle increment).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 2);

   logic [1:0]    r_sync;
   logic          r_deb;
   logic          r_deb_d;
   logic [DW-1:0] r_dcnt;
   logic [RW-1:0] r_rcnt;
   logic          r_pulse;

   logic w_rise;
   logic w_held;
   logic w_rep;

   assign w_rise = r_deb & ~r_deb_d;
   // Repeat only while the synced raw level is still high, so a release
   // stops repeats without waiting for the falling debounce window.
   assign w_held = r_deb & r_deb_d & r_sync[1];
   assign w_rep  = (REPEAT_CYCLES > 0) && w_held &&
                   (r_rcnt == RW'(REPEAT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_deb   <= 1'b0;
         r_deb_d <= 1'b0;
         r_dcnt  <= '0;
         r_rcnt  <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_deb_d <= r_deb;
         if (r_sync[1] != r_deb) begin
            if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb  <= r_sync[1];
               r_dcnt <= '0;
            end else begin
               r_dcnt <= r_dcnt + 1'b1;
            end
         end else begin
            r_dcnt <= '0;
         end
         if (w_rise || !w_held || w_rep) begin
            r_rcnt <= '0;
         end else begin
            r_rcnt <= r_rcnt + 1'b1;
         end
         r_pulse <= w_rise | w_rep;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: IDLE/EDIT/LOAD FSM plus the four editable fields.
// Ports: set_mode, *_sw field selects, add_time button, load_ack in;
//        ms_o/sec_o/min_o/hr_o, field_sel, editing, load_req out (registered).
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_mode,
   input  logic       ms_sw,
   input  logic       s_sw,
   input  logic       min_sw,
   input  logic       hr_sw,
   input  logic       add_time,
   input  logic       load_ack,
   output logic [9:0] ms_o,
   output logic [5:0] sec_o,
   output logic [5:0] min_o,
   output logic [4:0] hr_o,
   output logic [1:0] field_sel,
   output logic       editing,
   output logic       load_req
);

   logic [1:0] r_rst_q;
   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_editing;
   logic       r_load_req;
   field_t     r_field_sel;
   logic [9:0] r_ms;
   logic [5:0] r_sec;
   logic [5:0] r_min;
   logic [4:0] r_hr;

   logic   w_pulse;
   logic   w_any_sw;
   field_t w_sel;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (add_time),
      .o_pulse (w_pulse)
   );

   assign w_any_sw = ms_sw | s_sw | min_sw | hr_sw;
   assign w_sel    = pick_field(ms_sw, s_sw, min_sw);

   // Deassertion of rst_n is re-timed here; FSM stays in IDLE until done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_q <= '0;
      end else begin
         r_rst_q <= {r_rst_q[0], 1'b1};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (set_mode && r_rst_q[1]) w_state_nxt = ST_EDIT;
         ST_EDIT: if (!set_mode)              w_state_nxt = ST_LOAD;
         ST_LOAD: if (r_load_req && load_ack) w_state_nxt = ST_IDLE;
         default:                             w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_editing  <= 1'b0;
         r_load_req <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_editing  <= (w_state_nxt == ST_EDIT);
         r_load_req <= (w_state_nxt == ST_LOAD);
      end
   end

   // Live switches pick the target, so a switch change coinciding with
   // a pulse steers that increment to the newly selected field.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_field_sel <= FLD_MS;
         r_ms        <= '0;
         r_sec       <= '0;
         r_min       <= '0;
         r_hr        <= '0;
      end else if (r_state == ST_EDIT) begin
         if (w_any_sw) r_field_sel <= w_sel;
         if (w_pulse && w_any_sw) begin
            unique case (w_sel)
               FLD_MS:  r_ms  <= (r_ms  >= MS_MAX)  ? '0 : r_ms  + 10'd1;
               FLD_SEC: r_sec <= (r_sec >= SEC_MAX) ? '0 : r_sec + 6'd1;
               FLD_MIN: r_min <= (r_min >= MIN_MAX) ? '0 : r_min + 6'd1;
               FLD_HR:  r_hr  <= (r_hr  >= HR_MAX)  ? '0 : r_hr  + 5'd1;
            endcase
         end
      end
   end

   assign ms_o      = r_ms;
   assign sec_o     = r_sec;
   assign min_o     = r_min;
   assign hr_o      = r_hr;
   assign field_sel = r_field_sel;
   assign editing   = r_editing;
   assign load_req  = r_load_req;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized and directed bench for time_set_ctrl against a
// plain-arithmetic reference of the field values.
module tb_time_set_ctrl;

   localparam int D = 4;
   localparam int R = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       set_mode;
   logic       ms_sw, s_sw, min_sw, hr_sw;
   logic       add_time;
   logic       load_ack;
   logic [9:0] ms_o;
   logic [5:0] sec_o;
   logic [5:0] min_o;
   logic [4:0] hr_o;
   logic [1:0] field_sel;
   logic       editing;
   logic       load_req;

   int n_err = 0;
   int n_chk = 0;

   int m_ms, m_sec, m_min, m_hr, m_fsel;
   bit m_edit;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_mode  (set_mode),
      .ms_sw     (ms_sw),
      .s_sw      (s_sw),
      .min_sw    (min_sw),
      .hr_sw     (hr_sw),
      .add_time  (add_time),
      .load_ack  (load_ack),
      .ms_o      (ms_o),
      .sec_o     (sec_o),
      .min_o     (min_o),
      .hr_o      (hr_o),
      .field_sel (field_sel),
      .editing   (editing),
      .load_req  (load_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Number of increments a clean press of len cycles yields: one once
   // the level survives the debounce window, then one per R cycles for
   // as long as the synchronized button is still seen high.
   function automatic int n_inc(input int len);
      if (len < D) return 0;
      if (R == 0) return 1;
      return 1 + (len - D - 1) / R;
   endfunction

   task automatic model_add(input int n);
      if (!m_edit || n == 0) return;
      if (ms_sw)       m_ms  = (m_ms  + n) % 1000;
      else if (s_sw)   m_sec = (m_sec + n) % 60;
      else if (min_sw) m_min = (m_min + n) % 60;
      else if (hr_sw)  m_hr  = (m_hr  + n) % 24;
   endtask

   task automatic press(input int len);
      add_time = 1'b1;
      cyc(len);
      add_time = 1'b0;
      cyc(D + 8);
      model_add(n_inc(len));
   endtask

   task automatic set_sw(input logic [3:0] sw);
      ms_sw  = sw[0];
      s_sw   = sw[1];
      min_sw = sw[2];
      hr_sw  = sw[3];
      if (sw[0])      m_fsel = 0;
      else if (sw[1]) m_fsel = 1;
      else if (sw[2]) m_fsel = 2;
      else if (sw[3]) m_fsel = 3;
      cyc(2);
   endtask

   task automatic chk_fields(input string tag);
      chk({tag, ".ms"},  int'(ms_o),  m_ms);
      chk({tag, ".sec"}, int'(sec_o), m_sec);
      chk({tag, ".min"}, int'(min_o), m_min);
      chk({tag, ".hr"},  int'(hr_o),  m_hr);
   endtask

   initial begin
      int v;
      int k;
      logic [3:0] sw;
      rst_n    = 1'b0;
      set_mode = 1'b0;
      ms_sw    = 1'b0;
      s_sw     = 1'b0;
      min_sw   = 1'b0;
      hr_sw    = 1'b0;
      add_time = 1'b0;
      load_ack = 1'b0;
      m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0; m_fsel = 0;
      m_edit = 1'b0;

      cyc(3);
      chk_fields("rst");
      chk("rst.fsel", int'(field_sel), 0);
      chk("rst.edit", int'(editing), 0);
      chk("rst.lreq", int'(load_req), 0);

      // set_mode already high at release: FSM must wait for re-timed reset
      set_mode = 1'b1;
      rst_n    = 1'b1;
      cyc(1);
      chk("rstsync.hold", int'(editing), 0);
      cyc(3);
      chk("enter.edit", int'(editing), 1);
      m_edit = 1'b1;

      // load_ack outside LOAD has no effect
      load_ack = 1'b1;
      cyc(2);
      load_ack = 1'b0;
      chk("ack.ignored", int'(editing), 1);

      // latency: field moves exactly D+4 edges after the rise
      set_sw(4'b0010);
      add_time = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         cyc(1);
         if (e == D + 3) chk("lat.before", int'(sec_o), 0);
         if (e == D + 4) chk("lat.at", int'(sec_o), 1);
      end
      add_time = 1'b0;
      cyc(D + 8);
      m_sec = 1;
      chk("fsel.sec", int'(field_sel), 1);

      // short glitch is filtered out
      add_time = 1'b1;
      cyc(2);
      add_time = 1'b0;
      cyc(D + 8);
      chk_fields("glitch");

      // random switch sets and press lengths, incl. sub-debounce glitches
      for (int i = 0; i < 40; i++) begin
         sw = 4'($urandom_range(0, 15));
         set_sw(sw);
         press($urandom_range(1, D + 16));
         chk_fields($sformatf("rnd%0d", i));
         chk($sformatf("rnd%0d.fsel", i), int'(field_sel), m_fsel);
      end

      // hours up to 23 using auto-repeat, then wrap
      set_sw(4'b1000);
      k = 23 - m_hr;
      if (k > 0) press(D + 1 + R * (k - 1));
      chk("hr.max", int'(hr_o), 23);
      press(10);
      chk("hr.wrap", int'(hr_o), 0);
      chk("hr.wrapm", int'(hr_o), m_hr);

      // milliseconds up to 999, then wrap without carry into seconds
      set_sw(4'b0001);
      k = 999 - m_ms;
      if (k > 0) press(D + 1 + R * (k - 1));
      chk("ms.max", int'(ms_o), 999);
      v = int'(sec_o);
      press(10);
      chk("ms.wrap", int'(ms_o), 0);
      chk("ms.nocarry", int'(sec_o), v);
      chk_fields("ms");

      // ms and hr together: ms wins
      set_sw(4'b1001);
      v = m_hr;
      press(10);
      chk("prio.fsel", int'(field_sel), 0);
      chk("prio.ms", int'(ms_o), 1);
      chk("prio.hr", int'(hr_o), v);

      // 100-cycle hold on minutes
      set_sw(4'b0100);
      v = m_min;
      add_time = 1'b1;
      cyc(100);
      add_time = 1'b0;
      cyc(D + 8);
      chk("hold100", (int'(min_o) - v + 60) % 60, 1 + (100 - D - 4) / R);
      m_min = (v + 1 + (100 - D - 4) / R) % 60;
      chk_fields("hold");

      // LOAD: held request, presses and set_mode ignored
      set_mode = 1'b0;
      m_edit   = 1'b0;
      cyc(2);
      chk("load.req", int'(load_req), 1);
      chk("load.edit", int'(editing), 0);
      set_sw(4'b0001);
      set_mode = 1'b1;
      cyc(10);
      chk("load.hold", int'(load_req), 1);
      press(10);
      set_mode = 1'b0;
      cyc(1);
      chk("load.stay", int'(load_req), 1);
      chk_fields("load");
      load_ack = 1'b1;
      cyc(1);
      load_ack = 1'b0;
      chk("ack.req", int'(load_req), 0);
      chk("ack.edit", int'(editing), 0);

      // presses in IDLE are discarded
      press(10);
      chk_fields("idle");

      // reset while in LOAD
      set_mode = 1'b1;
      cyc(4);
      chk("re.edit", int'(editing), 1);
      set_mode = 1'b0;
      cyc(2);
      chk("re.load", int'(load_req), 1);
      #2;
      rst_n = 1'b0;
      #1;
      m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
      chk("arst.lreq", int'(load_req), 0);
      chk("arst.fsel", int'(field_sel), 0);
      chk_fields("arst");
      cyc(2);
      rst_n = 1'b1;
      cyc(4);
      chk("post.lreq", int'(load_req), 0);
      chk("post.edit", int'(editing), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
